// File: rtl/tcdm_amo_pkg.sv
// Shared types for the TCDM bank arbiter and the AMO shim it feeds.
package tcdm_amo_pkg;

  localparam int unsigned AmoOpWidth = 4;

  typedef enum logic [AmoOpWidth-1:0] {
    AMO_NONE = 4'h0,
    AMO_SWAP = 4'h1,
    AMO_ADD  = 4'h2,
    AMO_AND  = 4'h3,
    AMO_OR   = 4'h4,
    AMO_XOR  = 4'h5,
    AMO_MAX  = 4'h6,
    AMO_MAXU = 4'h7,
    AMO_MIN  = 4'h8,
    AMO_MINU = 4'h9,
    AMO_CAS  = 4'hA
  } amo_op_t;

endpackage

// File: rtl/rr_lock_arb.sv
// Round-robin arbiter that holds its choice while the downstream stalls,
// so a presented request never changes until it is granted.
module rr_lock_arb #(
  parameter  int unsigned NumIn    = 4,
  localparam int unsigned IdxWidth = $clog2(NumIn)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumIn-1:0]    req_i,
  input  logic                gnt_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  logic [IdxWidth-1:0] rr_ptr_q;
  logic [IdxWidth-1:0] sel_q;
  logic                lock_q;
  logic [IdxWidth-1:0] scan_idx;
  logic                scan_found;
  logic                lock_hit;
  logic [IdxWidth-1:0] winner;
  int unsigned         cand;

  always_comb begin
    scan_idx   = '0;
    scan_found = 1'b0;
    cand       = 0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      cand = (32'(rr_ptr_q) + i) % NumIn;
      if (!scan_found && req_i[cand]) begin
        scan_found = 1'b1;
        scan_idx   = IdxWidth'(cand);
      end
    end
  end

  // A locked requester that illegally drops req is ignored rather than wedging the bank.
  assign lock_hit = lock_q & req_i[sel_q];
  assign winner   = lock_hit ? sel_q : scan_idx;
  assign idx_o    = winner;
  assign valid_o  = |req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
    end else if (valid_o) begin
      if (gnt_i) begin
        rr_ptr_q <= (winner == IdxWidth'(NumIn - 1)) ? '0 : winner + 1'b1;
        lock_q   <= 1'b0;
      end else begin
        lock_q <= 1'b1;
        sel_q  <= winner;
      end
    end else begin
      lock_q <= 1'b0;
    end
  end

endmodule

// File: rtl/tcdm_amo_bank_arbiter.sv
// Shares one AMO-shim-fronted SRAM bank between NumIn TCDM requesters and
// routes the one-cycle read response back to whoever was granted.
module tcdm_amo_bank_arbiter
  import tcdm_amo_pkg::*;
#(
  parameter  int unsigned NumIn         = 4,
  parameter  int unsigned AddrMemWidth  = 32,
  parameter  int unsigned DataWidth     = 64,
  parameter  int unsigned StallCntWidth = 16,
  localparam int unsigned BeWidth       = DataWidth / 8,
  localparam int unsigned IdxWidth      = $clog2(NumIn)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumIn-1:0]         req_i,
  output logic [NumIn-1:0]         gnt_o,
  input  logic [AddrMemWidth-1:0]  add_i   [NumIn],
  input  logic [AmoOpWidth-1:0]    amo_i   [NumIn],
  input  logic [NumIn-1:0]         wen_i,
  input  logic [DataWidth-1:0]     wdata_i [NumIn],
  input  logic [BeWidth-1:0]       be_i    [NumIn],
  output logic [DataWidth-1:0]     rdata_o,
  output logic [NumIn-1:0]         rvalid_o,
  output logic                     out_req_o,
  input  logic                     out_gnt_i,
  output logic [AddrMemWidth-1:0]  out_add_o,
  output logic [AmoOpWidth-1:0]    out_amo_o,
  output logic                     out_wen_o,
  output logic [DataWidth-1:0]     out_wdata_o,
  output logic [BeWidth-1:0]       out_be_o,
  input  logic [DataWidth-1:0]     out_rdata_i,
  output logic [StallCntWidth-1:0] stall_cnt_o
);

  if (NumIn < 2 || (DataWidth != 32 && DataWidth != 64)) begin : g_bad_params
    $error("tcdm_amo_bank_arbiter: NumIn must be >= 2 and DataWidth 32 or 64");
  end

  logic [IdxWidth-1:0]      win_idx;
  logic                     win_valid;
  logic [NumIn-1:0]         rvalid_q;
  logic [StallCntWidth-1:0] stall_cnt_q;

  rr_lock_arb #(
    .NumIn (NumIn)
  ) i_rr_lock_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .gnt_i   (out_gnt_i),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign out_req_o = win_valid;

  always_comb begin
    out_add_o   = '0;
    out_amo_o   = '0;
    out_wen_o   = 1'b0;
    out_wdata_o = '0;
    out_be_o    = '0;
    gnt_o       = '0;
    if (out_req_o) begin
      out_add_o        = add_i[win_idx];
      out_amo_o        = amo_i[win_idx];
      out_wen_o        = wen_i[win_idx];
      out_wdata_o      = wdata_i[win_idx];
      out_be_o         = be_i[win_idx];
      gnt_o[win_idx]   = out_gnt_i;
    end
  end

  // gnt_o is already onehot(winner) on a handshake and zero otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      rvalid_q <= gnt_o;
      if (out_req_o && !out_gnt_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = out_rdata_i;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_tcdm_amo_bank_arbiter.sv
// Self-checking bench: directed vector table, hand-written stall/reset
// sequences and a randomized run against a behavioural arbiter model.
module tb_tcdm_amo_bank_arbiter;
  import tcdm_amo_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int SW = 4;
  localparam int SAT = (1 << SW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [N-1:0]  gnt_o;
  logic [AW-1:0] add_i   [N];
  logic [3:0]    amo_i   [N];
  logic [N-1:0]  wen_i = '0;
  logic [DW-1:0] wdata_i [N];
  logic [BW-1:0] be_i    [N];
  logic [DW-1:0] rdata_o;
  logic [N-1:0]  rvalid_o;
  logic          out_req_o;
  logic          out_gnt_i = 1'b0;
  logic [AW-1:0] out_add_o;
  logic [3:0]    out_amo_o;
  logic          out_wen_o;
  logic [DW-1:0] out_wdata_o;
  logic [BW-1:0] out_be_o;
  logic [DW-1:0] out_rdata_i = '0;
  logic [SW-1:0] stall_cnt_o;

  tcdm_amo_bank_arbiter #(
    .NumIn(N), .AddrMemWidth(AW), .DataWidth(DW), .StallCntWidth(SW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .amo_i(amo_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
    .out_amo_o(out_amo_o), .out_wen_o(out_wen_o), .out_wdata_o(out_wdata_o),
    .out_be_o(out_be_o), .out_rdata_i(out_rdata_i), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requesters must hold req until granted.
  logic [N-1:0] hold_q = '0;
  always @(posedge clk_i) begin
    if (rst_ni)
      for (int p = 0; p < N; p++)
        if (hold_q[p] && !req_i[p]) $error("protocol violation: port %0d dropped req before grant", p);
    hold_q <= req_i & ~gnt_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    req_i     = '0;
    out_gnt_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic          gnt;
    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  exp_rv;
    logic          exp_oreq;
    logic [AW-1:0] exp_add;
    logic [3:0]    exp_amo;
    logic [SW-1:0] exp_stall;
  } vec_t;

  vec_t vt[12];

  // Behavioural model state for the random phase.
  int           m_ptr, m_lock, m_stall;
  logic [N-1:0] m_rv;

  initial begin
    logic [DW-1:0] rd;
    //          req      g  gnt      rvalid   oreq  add    amo stall
    vt[0]  = '{4'b0100, 1, 4'b0100, 4'b0000, 1, 32'h10, 0, 0};
    vt[1]  = '{4'b0000, 1, 4'b0000, 4'b0100, 0, 32'h00, 0, 0};
    vt[2]  = '{4'b1111, 1, 4'b1000, 4'b0000, 1, 32'h70, 0, 0};
    vt[3]  = '{4'b1111, 1, 4'b0001, 4'b1000, 1, 32'h40, 0, 0};
    vt[4]  = '{4'b1111, 1, 4'b0010, 4'b0001, 1, 32'h50, 2, 0};
    vt[5]  = '{4'b1111, 1, 4'b0100, 4'b0010, 1, 32'h10, 0, 0};
    vt[6]  = '{4'b1011, 1, 4'b1000, 4'b0100, 1, 32'h70, 0, 0};
    vt[7]  = '{4'b0011, 1, 4'b0001, 4'b1000, 1, 32'h40, 0, 0};
    vt[8]  = '{4'b1010, 1, 4'b0010, 4'b0001, 1, 32'h50, 2, 0};
    vt[9]  = '{4'b1000, 0, 4'b0000, 4'b0010, 1, 32'h70, 0, 0};
    vt[10] = '{4'b1000, 1, 4'b1000, 4'b0000, 1, 32'h70, 0, 1};
    vt[11] = '{4'b0000, 1, 4'b0000, 4'b1000, 0, 32'h00, 0, 1};

    add_i[0] = 32'h40; add_i[1] = 32'h50; add_i[2] = 32'h10; add_i[3] = 32'h70;
    for (int p = 0; p < N; p++) begin
      amo_i[p]   = (p == 1) ? 4'(AMO_ADD) : 4'(AMO_NONE);
      wdata_i[p] = 64'h1111 * (p + 1);
      be_i[p]    = 8'hFF;
    end

    do_reset();
    chk("reset gnt", gnt_o, 0);
    chk("reset rvalid", rvalid_o, 0);
    chk("reset stall", stall_cnt_o, 0);
    chk("reset out_req", out_req_o, 0);

    for (int i = 0; i < 12; i++) begin
      req_i       = vt[i].req;
      out_gnt_i   = vt[i].gnt;
      rd          = {$urandom, $urandom};
      out_rdata_i = rd;
      #1;
      chk($sformatf("v%0d gnt", i), gnt_o, vt[i].exp_gnt);
      chk($sformatf("v%0d rvalid", i), rvalid_o, vt[i].exp_rv);
      chk($sformatf("v%0d out_req", i), out_req_o, vt[i].exp_oreq);
      chk($sformatf("v%0d out_add", i), out_add_o, vt[i].exp_add);
      chk($sformatf("v%0d out_amo", i), out_amo_o, vt[i].exp_amo);
      chk($sformatf("v%0d stall", i), stall_cnt_o, vt[i].exp_stall);
      chk($sformatf("v%0d rdata", i), rdata_o, rd);
      next_cycle();
    end

    // Lock: port 0 stalls with pointer at 2; port 3 joins but must not steal the bank.
    do_reset();
    req_i = 4'b0010; out_gnt_i = 1'b1; #1;
    chk("lock pre gnt", gnt_o, 4'b0010);
    next_cycle();
    out_gnt_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_i = (k == 0) ? 4'b0001 : 4'b1001;
      #1;
      chk($sformatf("lock c%0d add", k), out_add_o, 32'h40);
      chk($sformatf("lock c%0d gnt", k), gnt_o, 0);
      next_cycle();
    end
    req_i = 4'b1001; out_gnt_i = 1'b1; #1;
    chk("lock release gnt", gnt_o, 4'b0001);
    chk("lock stall count", stall_cnt_o, 5);
    next_cycle();
    req_i = 4'b1000; #1;
    chk("lock next gnt", gnt_o, 4'b1000);
    chk("lock rvalid p0", rvalid_o, 4'b0001);
    next_cycle();
    req_i = 4'b0000; #1;
    chk("lock rvalid p3", rvalid_o, 4'b1000);

    // Saturation with a 4-bit counter over 20 stall cycles.
    do_reset();
    req_i = 4'b0001; out_gnt_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("sat c%0d", k), stall_cnt_o, (k > SAT) ? SAT : k);
      next_cycle();
    end
    chk("sat final", stall_cnt_o, SAT);

    // Reset asserted mid-stall with a response pending.
    do_reset();
    req_i = 4'b0010; out_gnt_i = 1'b0;
    next_cycle();
    out_gnt_i = 1'b1;
    next_cycle();
    req_i = 4'b0100; out_gnt_i = 1'b0; #1;
    chk("rst pre rvalid", rvalid_o, 4'b0010);
    chk("rst pre stall", stall_cnt_o, 1);
    rst_ni = 1'b0; #1;
    chk("rst mid rvalid", rvalid_o, 0);
    chk("rst mid gnt", gnt_o, 0);
    chk("rst mid stall", stall_cnt_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    req_i = 4'b1111; out_gnt_i = 1'b1; #1;
    chk("rst post gnt0", gnt_o, 4'b0001);
    next_cycle();
    chk("rst post gnt1", gnt_o, 4'b0010);
    chk("rst post rvalid", rvalid_o, 4'b0001);

    // Randomized run against the behavioural model.
    do_reset();
    m_ptr = 0; m_lock = -1; m_stall = 0; m_rv = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int w, gp;
      logic any;
      for (int p = 0; p < N; p++)
        if (!req_i[p] && $urandom_range(0, 99) < 40) begin
          req_i[p]   = 1'b1;
          add_i[p]   = $urandom;
          amo_i[p]   = 4'($urandom_range(0, 10));
          wen_i[p]   = 1'($urandom);
          wdata_i[p] = {$urandom, $urandom};
          be_i[p]    = 8'($urandom);
        end
      out_gnt_i   = ($urandom_range(0, 99) < 65);
      rd          = {$urandom, $urandom};
      out_rdata_i = rd;

      any = (req_i != 0);
      w = 0;
      if (m_lock >= 0 && req_i[m_lock]) w = m_lock;
      else
        for (int i = N - 1; i >= 0; i--)
          if (req_i[(m_ptr + i) % N]) w = (m_ptr + i) % N;

      #1;
      chk("rnd gnt", gnt_o, (any && out_gnt_i) ? (1 << w) : 0);
      chk("rnd out_req", out_req_o, any);
      chk("rnd out_add", out_add_o, any ? add_i[w] : 0);
      chk("rnd out_amo", out_amo_o, any ? amo_i[w] : 0);
      chk("rnd out_wen", out_wen_o, any ? wen_i[w] : 0);
      chk("rnd out_wdata", out_wdata_o, any ? wdata_i[w] : 0);
      chk("rnd out_be", out_be_o, any ? be_i[w] : 0);
      chk("rnd rvalid", rvalid_o, m_rv);
      chk("rnd stall", stall_cnt_o, m_stall);
      chk("rnd rdata", rdata_o, rd);

      gp = -1;
      if (any && out_gnt_i) begin
        m_ptr = (w + 1) % N; m_lock = -1; m_rv = N'(1 << w); gp = w;
      end else if (any) begin
        m_lock = w; m_rv = '0;
        if (m_stall < SAT) m_stall++;
      end else begin
        m_lock = -1; m_rv = '0;
      end

      next_cycle();
      if (gp >= 0) begin
        if ($urandom_range(0, 1) == 0) req_i[gp] = 1'b0;
        else begin
          add_i[gp]   = $urandom;
          amo_i[gp]   = 4'($urandom_range(0, 10));
          wen_i[gp]   = 1'($urandom);
          wdata_i[gp] = {$urandom, $urandom};
          be_i[gp]    = 8'($urandom);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
